// File: rtl/unsigned_trunc_mult_pipe_if.sv
// unsigned_trunc_mult_pipe_if: operand/product valid-ready stream bundle for the truncated multiplier
interface unsigned_trunc_mult_pipe_if #(
   parameter int WIDTH = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   x;
   logic [WIDTH-1:0]   y;
   logic               approx;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] z;
   logic               z_approx;
   modport master (
      output in_valid, x, y, approx, out_ready,
      input  in_ready, out_valid, z, z_approx
   );
   modport slave (
      input  in_valid, x, y, approx, out_ready,
      output in_ready, out_valid, z, z_approx
   );
endinterface

// File: rtl/unsigned_trunc_mult_pipe.sv
// unsigned_trunc_mult_pipe: two-stage exact/truncated unsigned multiplier with approx-beat counter
module unsigned_trunc_mult_pipe #(
   parameter int WIDTH = 8,
   parameter int L     = 4,
   parameter int CNT_W = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   unsigned_trunc_mult_pipe_if.slave bus,
   output logic [CNT_W-1:0]          approx_cnt
);
   localparam int WW = 2 * WIDTH;
   logic             s1_valid;
   logic             s1_approx;
   logic [WIDTH-1:0] s1_x;
   logic [WIDTH-1:0] s1_y;
   logic             s2_adv;
   logic             accept;
   logic [WW-1:0]    p_exact;
   logic [WW-1:0]    p_trunc;
   logic [WW-1:0]    comp;
   logic [WW-1:0]    z_next;
   assign s2_adv       = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = !s1_valid || s2_adv;
   assign accept       = bus.in_valid && bus.in_ready;
   // S1 captures operands whenever it is empty or its content moves into S2
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_approx <= 1'b0;
         s1_x      <= '0;
         s1_y      <= '0;
      end else if (bus.in_ready) begin
         s1_valid <= bus.in_valid;
         if (accept) begin
            s1_x      <= bus.x;
            s1_y      <= bus.y;
            s1_approx <= bus.approx;
         end
      end
   end
   // product of the S1 operands: exact, or high-part product plus OR-compressed dropped columns
   always_comb begin
      p_exact = WW'(s1_x) * WW'(s1_y);
      p_trunc = (WW'(s1_y) * WW'(s1_x[WIDTH-1:L])) << L;
      comp    = '0;
      for (int c = WIDTH; c <= WIDTH + L - 2; c++)
         for (int i = 0; i < L; i++)
            if (c - i >= 0 && c - i <= WIDTH - 1)
               comp[c] = comp[c] | (s1_x[i] & s1_y[c-i]);
      z_next = s1_approx ? p_trunc + comp : p_exact;
   end
   // S2 holds the registered result and stays frozen while downstream stalls
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.z         <= '0;
         bus.z_approx  <= 1'b0;
      end else if (s2_adv) begin
         bus.out_valid <= s1_valid;
         if (s1_valid) begin
            bus.z        <= z_next;
            bus.z_approx <= s1_approx;
         end
      end
   end
   // saturating count of accepted approximate beats
   always_ff @(posedge clk) begin
      if (!rst_n)
         approx_cnt <= '0;
      else if (accept && bus.approx && !(&approx_cnt))
         approx_cnt <= approx_cnt + CNT_W'(1);
   end
endmodule

// File: tb/tb_unsigned_trunc_mult_pipe.sv
// tb_unsigned_trunc_mult_pipe: directed and scoreboard checks of the truncated multiplier pipeline
module tb_unsigned_trunc_mult_pipe;
   localparam int W  = 8;
   localparam int LB = 4;
   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] cnt_a;
   logic [1:0]  cnt_b;
   int          total = 0;
   int          passed = 0;
   int          cyc = 0;
   int          exp_cnt = 0;
   int          delivered = 0;
   logic [16:0] q[$];
   logic        hold = 1'b0;
   logic [16:0] held = '0;
   logic [7:0]  bx[6] = '{8'd3, 8'd200, 8'd255, 8'd17, 8'd128, 8'd90};
   logic [7:0]  by[6] = '{8'd5, 8'd7, 8'd1, 8'd240, 8'd255, 8'd33};
   logic [7:0]  sy[5] = '{8'h00, 8'h01, 8'h5A, 8'hA5, 8'hFF};
   logic [1:0]  sat_exp[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
   int          c0;
   int          d0;
   always #5 clk = ~clk;
   unsigned_trunc_mult_pipe_if #(.WIDTH(W)) ifa ();
   unsigned_trunc_mult_pipe_if #(.WIDTH(W)) ifb ();
   unsigned_trunc_mult_pipe #(.WIDTH(W), .L(LB), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa), .approx_cnt(cnt_a)
   );
   unsigned_trunc_mult_pipe #(.WIDTH(W), .L(LB), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb), .approx_cnt(cnt_b)
   );
   function automatic logic [15:0] model(logic [7:0] a, logic [7:0] b, logic ap);
      logic [31:0] s;
      logic [15:0] col;
      s   = '0;
      col = '0;
      for (int i = 0; i < W; i++)
         for (int j = 0; j < W; j++)
            if (a[i] & b[j]) begin
               if (!ap || i >= LB) s = s + (32'd1 << (i + j));
               else if (i + j >= W && i + j <= W + LB - 2) col[i+j] = 1'b1;
            end
      return 16'(s + 32'(col));
   endfunction
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         hold    = 1'b0;
         exp_cnt = 0;
      end else begin
         if (hold && ifa.out_valid) check("hold", {ifa.z_approx, ifa.z}, held);
         if (ifa.out_valid && ifa.out_ready) begin
            delivered++;
            if (q.size() == 0) check("spurious", 1, 0);
            else check("scoreboard", {ifa.z_approx, ifa.z}, q.pop_front());
         end
         hold = ifa.out_valid && !ifa.out_ready;
         held = {ifa.z_approx, ifa.z};
         if (ifa.in_valid && ifa.in_ready) begin
            q.push_back({ifa.approx, model(ifa.x, ifa.y, ifa.approx)});
            if (ifa.approx) exp_cnt++;
         end
      end
   end
   task automatic send(logic [7:0] a, logic [7:0] b, logic ap);
      int n = 0;
      ifa.in_valid = 1'b1;
      ifa.x        = a;
      ifa.y        = b;
      ifa.approx   = ap;
      @(negedge clk);
      while (!ifa.in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (n >= 50) check("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask
   task automatic drain();
      int n = 0;
      ifa.in_valid = 1'b0;
      while (q.size() > 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain", q.size(), 0);
   endtask
   task automatic single(string tag, logic [7:0] a, logic [7:0] b, logic ap, logic [15:0] expz);
      send(a, b, ap);
      ifa.in_valid = 1'b0;
      @(negedge clk);
      check({tag, "_early"}, ifa.out_valid, 0);
      @(negedge clk);
      check({tag, "_valid"}, ifa.out_valid, 1);
      check({tag, "_z"}, ifa.z, expz);
      check({tag, "_za"}, ifa.z_approx, ap);
      @(posedge clk);
      #1;
   endtask
   initial begin
      ifa.in_valid = 1'b0; ifa.x = '0; ifa.y = '0; ifa.approx = 1'b0; ifa.out_ready = 1'b1;
      ifb.in_valid = 1'b0; ifb.x = '0; ifb.y = '0; ifb.approx = 1'b0; ifb.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_out_valid", ifa.out_valid, 0);
      check("rst_z", ifa.z, 0);
      check("rst_z_approx", ifa.z_approx, 0);
      check("rst_cnt", cnt_a, 0);
      check("rst_in_ready", ifa.in_ready, 1);
      single("exact_ff", 8'hFF, 8'hFF, 1'b0, 16'd65025);
      single("apx_ff", 8'hFF, 8'hFF, 1'b1, 16'd62992);
      single("apx_0f", 8'h0F, 8'hFF, 1'b1, 16'd1792);
      single("apx_10", 8'h10, 8'h03, 1'b1, 16'd48);
      check("cnt_three", cnt_a, 3);
      d0 = delivered;
      fork
         begin
            for (int i = 0; i < 6; i++) send(bx[i], by[i], i[0]);
            ifa.in_valid = 1'b0;
         end
         begin
            repeat (2) @(posedge clk);
            #1 ifa.out_ready = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            check("bp_in_ready", ifa.in_ready, 0);
            check("bp_out_valid", ifa.out_valid, 1);
            repeat (3) @(posedge clk);
            #1 ifa.out_ready = 1'b1;
         end
      join
      drain();
      check("bp_count", delivered - d0, 6);
      c0 = cyc;
      d0 = delivered;
      for (int i = 0; i < 100; i++) send(8'($urandom), 8'($urandom), 1'($urandom));
      check("thru_cycles", cyc - c0, 100);
      drain();
      check("rand_count", delivered - d0, 100);
      for (int a = 0; a < 256; a++)
         for (int k = 0; k < 10; k++) send(8'(a), sy[k % 5], k >= 5);
      drain();
      check("cnt_model", cnt_a, exp_cnt);
      send(8'd11, 8'd13, 1'b1);
      send(8'd200, 8'd3, 1'b0);
      ifa.in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_valid", ifa.out_valid, 0);
      check("mid_rst_cnt", cnt_a, 0);
      check("mid_rst_z", ifa.z, 0);
      rst_n = 1'b1;
      check("mid_rst_in_ready", ifa.in_ready, 1);
      repeat (4) begin
         @(negedge clk);
         check("no_stale", ifa.out_valid, 0);
      end
      @(posedge clk);
      #1;
      check("sat_start", cnt_b, 0);
      ifb.in_valid = 1'b1;
      ifb.approx   = 1'b1;
      ifb.x        = 8'h21;
      ifb.y        = 8'h43;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("sat", cnt_b, sat_exp[i]);
      end
      ifb.in_valid = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
